// File: rtl/life_pipe.sv
// rtl/life_pipe.sv - streaming B3/S23 next-generation pipeline over a raster cell stream
// Optional feature macro LIFE_PIPE_POP_EN adds the per-generation population output.
module life_pipe #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt_bit,
  input  logic        cell_in,
  input  logic        sync,
  output logic        pipe_out,
  output logic        out_valid,
  output logic        gen_done,
  output logic [15:0] gen_count
`ifdef LIFE_PIPE_POP_EN
  ,
  output logic [LOG2X+LOG2Y:0] population
`endif
);

  localparam int W = 2*X + 3;
  localparam logic [LOG2X-1:0] X_LAST    = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_LAST    = LOG2Y'(Y - 1);
  localparam logic [LOG2X:0]   FILL_LAST = (LOG2X+1)'(X);

  typedef enum logic {FILL, RUN} state_e;

  state_e           state_q;
  logic [W-1:0]     win_q;
  logic [W-1:0]     win_d;
  logic [LOG2X-1:0] cx_q;
  logic [LOG2Y-1:0] cy_q;
  logic [LOG2X:0]   fill_q;
  logic             pipe_q;
  logic             valid_q;
  logic             done_q;
  logic [15:0]      gen_q;

  logic       left_edge, right_edge, top_edge, bot_edge;
  logic       last_cell;
  logic       run_stb;
  logic [3:0] nbr;
  logic       live_d;
  logic       unused_win_msb;

  // Neighbourhood is evaluated on the window including the cell arriving this strobe.
  assign win_d          = {win_q[W-2:0], cell_in};
  assign unused_win_msb = win_q[W-1];

  assign left_edge  = (cx_q == '0);
  assign right_edge = (cx_q == X_LAST);
  assign top_edge   = (cy_q == '0);
  assign bot_edge   = (cy_q == Y_LAST);
  assign last_cell  = right_edge && bot_edge;
  assign run_stb    = !rst && !sync && nxt_bit && (state_q == RUN);

  always_comb begin
    nbr = 4'd0;
    if (!bot_edge) begin
      nbr = nbr + {3'd0, win_d[1]};
      if (!right_edge) nbr = nbr + {3'd0, win_d[0]};
      if (!left_edge)  nbr = nbr + {3'd0, win_d[2]};
    end
    if (!right_edge) nbr = nbr + {3'd0, win_d[X]};
    if (!left_edge)  nbr = nbr + {3'd0, win_d[X+2]};
    if (!top_edge) begin
      nbr = nbr + {3'd0, win_d[2*X+1]};
      if (!right_edge) nbr = nbr + {3'd0, win_d[2*X]};
      if (!left_edge)  nbr = nbr + {3'd0, win_d[2*X+2]};
    end
    live_d = (nbr == 4'd3) || (win_d[X+1] && (nbr == 4'd2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      win_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      fill_q  <= '0;
      pipe_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      gen_q   <= 16'd0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (sync) begin
        state_q <= FILL;
        cx_q    <= '0;
        cy_q    <= '0;
        if (nxt_bit) begin
          win_q  <= {{(W-1){1'b0}}, cell_in};
          fill_q <= (LOG2X+1)'(1);
        end else begin
          win_q  <= '0;
          fill_q <= '0;
        end
      end else if (nxt_bit) begin
        win_q <= win_d;
        case (state_q)
          FILL: begin
            if (fill_q == FILL_LAST) begin
              state_q <= RUN;
              fill_q  <= '0;
              cx_q    <= '0;
              cy_q    <= '0;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
          RUN: begin
            pipe_q  <= live_d;
            valid_q <= 1'b1;
            if (right_edge) begin
              cx_q <= '0;
              cy_q <= bot_edge ? '0 : cy_q + 1'b1;
            end else begin
              cx_q <= cx_q + 1'b1;
            end
            if (last_cell) begin
              done_q <= 1'b1;
              gen_q  <= gen_q + 16'd1;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

`ifdef LIFE_PIPE_POP_EN
  localparam int POPW = LOG2X + LOG2Y + 1;

  logic [POPW-1:0] pop_acc_q;
  logic [POPW-1:0] pop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_acc_q <= '0;
      pop_q     <= '0;
    end else if (sync) begin
      pop_acc_q <= '0;
    end else if (run_stb) begin
      if (last_cell) begin
        pop_q     <= pop_acc_q + POPW'(live_d);
        pop_acc_q <= '0;
      end else begin
        pop_acc_q <= pop_acc_q + POPW'(live_d);
      end
    end
  end

  assign population = pop_q;
`else
  logic unused_run_stb;
  assign unused_run_stb = run_stb;
`endif

  assign pipe_out  = pipe_q;
  assign out_valid = valid_q;
  assign gen_done  = done_q;
  assign gen_count = gen_q;

endmodule
